// File: rtl/pipeline_ctrl.sv
// Stall/flush/interrupt sequencer for the 5-stage OTTER pipeline (IF, DE, EX, MEM, WB).
// Hazards and enables are combinational; only the stage valid bits and the interrupt FSM are registered.
module pipeline_ctrl #(
  parameter int INT_PC_SRC = 4,
  parameter int PC_SRC_W   = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [31:0]         DEC_IR,
  input  logic [31:0]         EXE_IR,
  input  logic [31:0]         MEM_IR,
  input  logic [PC_SRC_W-1:0] DEC_PC_SOURCE,
  input  logic                DEC_CLEAR,
  input  logic                MEM_BUSY,
  input  logic                INTR,
  input  logic                CSR_MIE,
  output logic                PC_WE,
  output logic [PC_SRC_W-1:0] PC_SOURCE,
  output logic                IF_DE_WE,
  output logic                DE_EX_WE,
  output logic                EX_MEM_WE,
  output logic                MEM_WB_WE,
  output logic                FLUSH_IF_DE,
  output logic                BUBBLE_DE_EX,
  output logic                INT_TAKEN,
  output logic [1:0]          STATE_DBG
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, TAKE = 2'd2} state_t;

  state_t state_q, state_d;
  logic   v_de_q, v_ex_q, v_mem_q, v_wb_q;
  logic   v_de_d, v_ex_d, v_mem_d, v_wb_d;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc, input logic [2:0] f3);
    return (opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL || opc == OPC_JALR ||
            opc == OPC_OP_IMM || opc == OPC_OP || opc == OPC_LOAD ||
            (opc == OPC_SYSTEM && f3 != 3'd0));
  endfunction

  logic [6:0] dec_opc, exe_opc, mem_opc;
  logic [4:0] dec_rs1, dec_rs2, exe_rd, mem_rd;
  logic       dec_use1, dec_use2, dec_is_br;
  logic       exe_hit, mem_hit, load_use, br_dep, stall, redirect, int_rec;
  logic       unused_ir;

  assign dec_opc   = DEC_IR[6:0];
  assign exe_opc   = EXE_IR[6:0];
  assign mem_opc   = MEM_IR[6:0];
  assign dec_rs1   = DEC_IR[19:15];
  assign dec_rs2   = DEC_IR[24:20];
  assign exe_rd    = EXE_IR[11:7];
  assign mem_rd    = MEM_IR[11:7];
  assign dec_use1  = uses_rs1(dec_opc);
  assign dec_use2  = uses_rs2(dec_opc);
  assign dec_is_br = (dec_opc == OPC_BRANCH) || (dec_opc == OPC_JALR);
  assign unused_ir = ^{DEC_IR[31:25], DEC_IR[14:7], EXE_IR[31:15], MEM_IR[31:12]};

  // x0 is hard-wired, so a producer with rd = 0 never matches
  assign exe_hit = (exe_rd != 5'd0) &&
                   ((dec_use1 && exe_rd == dec_rs1) || (dec_use2 && exe_rd == dec_rs2));
  assign mem_hit = (mem_rd != 5'd0) &&
                   ((dec_use1 && mem_rd == dec_rs1) || (dec_use2 && mem_rd == dec_rs2));

  assign load_use = v_ex_q && (exe_opc == OPC_LOAD) && exe_hit;
  assign br_dep   = dec_is_br &&
                    ((v_ex_q && writes_rd(exe_opc, EXE_IR[14:12]) && exe_hit) ||
                     (v_mem_q && (mem_opc == OPC_LOAD) && mem_hit));
  assign stall    = v_de_q && (load_use || br_dep);
  assign redirect = DEC_CLEAR && v_de_q;
  assign int_rec  = (state_q == RUN) && INTR && CSR_MIE && v_de_q && !stall && !redirect;

  always_comb begin
    PC_WE        = 1'b0;
    PC_SOURCE    = DEC_PC_SOURCE;
    IF_DE_WE     = 1'b0;
    DE_EX_WE     = 1'b0;
    EX_MEM_WE    = 1'b0;
    MEM_WB_WE    = 1'b0;
    FLUSH_IF_DE  = 1'b0;
    BUBBLE_DE_EX = 1'b0;
    INT_TAKEN    = 1'b0;
    state_d      = state_q;
    if (RST) begin
      PC_SOURCE = '0;
    end else if (MEM_BUSY) begin
      state_d = state_q;
    end else if (state_q == TAKE) begin
      PC_WE        = 1'b1;
      PC_SOURCE    = PC_SRC_W'(INT_PC_SRC);
      INT_TAKEN    = 1'b1;
      FLUSH_IF_DE  = 1'b1;
      BUBBLE_DE_EX = 1'b1;
      IF_DE_WE     = 1'b1;
      DE_EX_WE     = 1'b1;
      EX_MEM_WE    = 1'b1;
      MEM_WB_WE    = 1'b1;
      state_d      = RUN;
    end else if (state_q == DRAIN || int_rec) begin
      // hold the DE instruction (its PC goes to mepc) while older ones retire
      BUBBLE_DE_EX = 1'b1;
      DE_EX_WE     = 1'b1;
      EX_MEM_WE    = 1'b1;
      MEM_WB_WE    = 1'b1;
      if (state_q == DRAIN)
        state_d = (v_ex_q || v_mem_q || v_wb_q) ? DRAIN : TAKE;
      else
        state_d = DRAIN;
    end else begin
      state_d = RUN;
      if (stall) begin
        BUBBLE_DE_EX = 1'b1;
        DE_EX_WE     = 1'b1;
        EX_MEM_WE    = 1'b1;
        MEM_WB_WE    = 1'b1;
      end else if (redirect) begin
        PC_WE       = 1'b1;
        PC_SOURCE   = DEC_PC_SOURCE;
        FLUSH_IF_DE = 1'b1;
        IF_DE_WE    = 1'b1;
        DE_EX_WE    = 1'b1;
        EX_MEM_WE   = 1'b1;
        MEM_WB_WE   = 1'b1;
      end else begin
        PC_WE     = 1'b1;
        PC_SOURCE = v_de_q ? DEC_PC_SOURCE : '0;
        IF_DE_WE  = 1'b1;
        DE_EX_WE  = 1'b1;
        EX_MEM_WE = 1'b1;
        MEM_WB_WE = 1'b1;
      end
    end
  end

  always_comb begin
    v_de_d  = v_de_q;
    v_ex_d  = v_ex_q;
    v_mem_d = v_mem_q;
    v_wb_d  = v_wb_q;
    if (!MEM_BUSY) begin
      v_wb_d  = v_mem_q;
      v_mem_d = v_ex_q;
      v_ex_d  = BUBBLE_DE_EX ? 1'b0 : v_de_q;
      v_de_d  = FLUSH_IF_DE ? 1'b0 : (IF_DE_WE ? 1'b1 : v_de_q);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      v_de_q  <= 1'b0;
      v_ex_q  <= 1'b0;
      v_mem_q <= 1'b0;
      v_wb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_de_q  <= v_de_d;
      v_ex_q  <= v_ex_d;
      v_mem_q <= v_mem_d;
      v_wb_q  <= v_wb_d;
    end
  end

  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized bench for pipeline_ctrl against an occupancy/register-set reference model.
module tb_pipeline_ctrl;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011,
                         OP_SYS = 7'b1110011;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] DEC_IR, EXE_IR, MEM_IR;
  logic [2:0]  DEC_PC_SOURCE;
  logic        DEC_CLEAR, MEM_BUSY, INTR, CSR_MIE;
  logic        PC_WE, IF_DE_WE, DE_EX_WE, EX_MEM_WE, MEM_WB_WE;
  logic        FLUSH_IF_DE, BUBBLE_DE_EX, INT_TAKEN;
  logic [2:0]  PC_SOURCE;
  logic [1:0]  STATE_DBG;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // model: occupancy of DE, EX, MEM, WB and interrupt phase (0 run, 1 drain, 2 take)
  bit   mv [4];
  int   mst;
  logic e_pcwe, e_ifde, e_deex, e_exmem, e_memwb, e_flush, e_bub, e_int;
  logic [2:0] e_pcs;

  pipeline_ctrl #(.INT_PC_SRC(4), .PC_SRC_W(3)) dut (
    .CLK(CLK), .RST(RST), .DEC_IR(DEC_IR), .EXE_IR(EXE_IR), .MEM_IR(MEM_IR),
    .DEC_PC_SOURCE(DEC_PC_SOURCE), .DEC_CLEAR(DEC_CLEAR), .MEM_BUSY(MEM_BUSY),
    .INTR(INTR), .CSR_MIE(CSR_MIE), .PC_WE(PC_WE), .PC_SOURCE(PC_SOURCE),
    .IF_DE_WE(IF_DE_WE), .DE_EX_WE(DE_EX_WE), .EX_MEM_WE(EX_MEM_WE),
    .MEM_WB_WE(MEM_WB_WE), .FLUSH_IF_DE(FLUSH_IF_DE), .BUBBLE_DE_EX(BUBBLE_DE_EX),
    .INT_TAKEN(INT_TAKEN), .STATE_DBG(STATE_DBG)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1,
                                      input int rs2, input int f3);
    return {7'b0, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] srcs(input logic [31:0] ir);
    logic [31:0] m;
    m = '0;
    if (!(ir[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL})) m[ir[19:15]] = 1'b1;
    if (ir[6:0] inside {OP_OP, OP_ST, OP_BR}) m[ir[24:20]] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] dsts(input logic [31:0] ir);
    logic [31:0] m;
    m = '0;
    if ((ir[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP, OP_LD}) ||
        (ir[6:0] == OP_SYS && ir[14:12] != 3'd0))
      m[ir[11:7]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic logic [31:0] rnd_ir();
    logic [6:0] op;
    case ($urandom_range(0, 10))
      0: op = OP_LUI;  1: op = OP_AUIPC; 2: op = OP_JAL; 3: op = OP_JALR;
      4: op = OP_BR;   5: op = OP_LD;    6: op = OP_ST;  7: op = OP_IMM;
      8: op = OP_OP;   9: op = OP_SYS;   default: op = 7'b1111111;
    endcase
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc_n, obs, exp);
    end
  endtask

  // evaluate the model for the current inputs, compare every output, then advance the model
  task automatic cyc();
    logic [31:0] sd;
    logic stall, redirect, rec;
    int nxt;
    #1;
    if (RST) begin
      for (int i = 0; i < 4; i++) mv[i] = 1'b0;
      mst = 0;
    end
    sd = srcs(DEC_IR);
    stall = mv[0] && (
              (mv[1] && EXE_IR[6:0] == OP_LD && |(sd & dsts(EXE_IR))) ||
              ((DEC_IR[6:0] inside {OP_BR, OP_JALR}) &&
               ((mv[1] && |(sd & dsts(EXE_IR))) ||
                (mv[2] && MEM_IR[6:0] == OP_LD && |(sd & dsts(MEM_IR))))));
    redirect = DEC_CLEAR && mv[0];
    rec = (mst == 0) && INTR && CSR_MIE && mv[0] && !stall && !redirect;
    nxt = mst;
    {e_pcwe, e_ifde, e_deex, e_exmem, e_memwb, e_flush, e_bub, e_int} = '0;
    e_pcs = DEC_PC_SOURCE;
    if (RST) begin
      e_pcs = 3'd0;
    end else if (MEM_BUSY) begin
      nxt = mst;
    end else if (mst == 2) begin
      {e_pcwe, e_ifde, e_deex, e_exmem, e_memwb, e_flush, e_bub, e_int} = '1;
      e_pcs = 3'd4;
      nxt = 0;
    end else if (mst == 1 || rec) begin
      {e_deex, e_exmem, e_memwb, e_bub} = '1;
      nxt = (mst == 0) ? 1 : ((mv[1] || mv[2] || mv[3]) ? 1 : 2);
    end else if (stall) begin
      {e_deex, e_exmem, e_memwb, e_bub} = '1;
    end else if (redirect) begin
      {e_pcwe, e_ifde, e_deex, e_exmem, e_memwb, e_flush} = '1;
    end else begin
      {e_pcwe, e_ifde, e_deex, e_exmem, e_memwb} = '1;
      e_pcs = mv[0] ? DEC_PC_SOURCE : 3'd0;
    end
    chk("pc_we", 32'(PC_WE), 32'(e_pcwe));
    chk("pc_source", 32'(PC_SOURCE), 32'(e_pcs));
    chk("if_de_we", 32'(IF_DE_WE), 32'(e_ifde));
    chk("de_ex_we", 32'(DE_EX_WE), 32'(e_deex));
    chk("ex_mem_we", 32'(EX_MEM_WE), 32'(e_exmem));
    chk("mem_wb_we", 32'(MEM_WB_WE), 32'(e_memwb));
    chk("flush_if_de", 32'(FLUSH_IF_DE), 32'(e_flush));
    chk("bubble_de_ex", 32'(BUBBLE_DE_EX), 32'(e_bub));
    chk("int_taken", 32'(INT_TAKEN), 32'(e_int));
    chk("state_dbg", 32'(STATE_DBG), 32'(mst));
    if (!RST && !MEM_BUSY) begin
      mv[3] = mv[2];
      mv[2] = mv[1];
      mv[1] = e_bub ? 1'b0 : mv[0];
      mv[0] = e_flush ? 1'b0 : (e_ifde ? 1'b1 : mv[0]);
      mst = nxt;
    end
    cyc_n++;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic nops(input int n);
    DEC_IR = enc(OP_IMM, 0, 0, 0, 0); EXE_IR = DEC_IR; MEM_IR = DEC_IR;
    DEC_CLEAR = 1'b0; INTR = 1'b0; MEM_BUSY = 1'b0; DEC_PC_SOURCE = 3'd0;
    for (int i = 0; i < n; i++) begin
      cyc(); tick();
    end
  endtask

  initial begin
    int exp_st [9];
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    mst = 0;
    RST = 1'b1; DEC_IR = enc(OP_IMM, 0, 0, 0, 0); EXE_IR = DEC_IR; MEM_IR = DEC_IR;
    DEC_PC_SOURCE = 3'd0; DEC_CLEAR = 1'b0; MEM_BUSY = 1'b0; INTR = 1'b0; CSR_MIE = 1'b0;
    tick();

    // reset values
    cyc();
    chk("rst_pc_we", 32'(PC_WE), 32'd0);
    chk("rst_state", 32'(STATE_DBG), 32'd0);
    tick();
    RST = 1'b0;

    // fill with NOPs
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("fill_we", 32'({PC_WE, IF_DE_WE, DE_EX_WE, EX_MEM_WE, MEM_WB_WE}), 32'h1f);
      chk("fill_int", 32'(INT_TAKEN), 32'd0);
      tick();
    end

    // load-use: lw x5 in EX, add x6,x5,x1 in DE
    DEC_IR = enc(OP_OP, 6, 5, 1, 0); EXE_IR = enc(OP_LD, 5, 1, 0, 2);
    cyc();
    chk("lu_pc_we", 32'(PC_WE), 32'd0);
    chk("lu_if_de_we", 32'(IF_DE_WE), 32'd0);
    chk("lu_bubble", 32'(BUBBLE_DE_EX), 32'd1);
    tick();
    EXE_IR = enc(OP_IMM, 0, 0, 0, 0); MEM_IR = enc(OP_LD, 5, 1, 0, 2);
    cyc();
    chk("lu_release", 32'(PC_WE), 32'd1);
    chk("lu_release_bub", 32'(BUBBLE_DE_EX), 32'd0);
    tick();
    nops(4);

    // branch on ALU result: one stall, then redirect
    DEC_IR = enc(OP_BR, 0, 7, 0, 0); EXE_IR = enc(OP_IMM, 7, 0, 0, 0);
    DEC_CLEAR = 1'b1; DEC_PC_SOURCE = 3'd2;
    cyc();
    chk("br_stall_pc_we", 32'(PC_WE), 32'd0);
    chk("br_stall_flush", 32'(FLUSH_IF_DE), 32'd0);
    tick();
    EXE_IR = enc(OP_IMM, 0, 0, 0, 0); MEM_IR = enc(OP_IMM, 7, 0, 0, 0);
    cyc();
    chk("br_redir_pc_we", 32'(PC_WE), 32'd1);
    chk("br_redir_src", 32'(PC_SOURCE), 32'd2);
    chk("br_redir_flush", 32'(FLUSH_IF_DE), 32'd1);
    tick();
    nops(4);

    // branch on load result: two stalls, then redirect
    DEC_IR = enc(OP_BR, 0, 7, 0, 0); EXE_IR = enc(OP_LD, 7, 1, 0, 2);
    DEC_CLEAR = 1'b1; DEC_PC_SOURCE = 3'd2;
    cyc(); chk("brl_stall1", 32'(PC_WE), 32'd0); tick();
    EXE_IR = enc(OP_IMM, 0, 0, 0, 0); MEM_IR = enc(OP_LD, 7, 1, 0, 2);
    cyc(); chk("brl_stall2", 32'(PC_WE), 32'd0); tick();
    MEM_IR = enc(OP_IMM, 0, 0, 0, 0);
    cyc();
    chk("brl_redir_pc_we", 32'(PC_WE), 32'd1);
    chk("brl_redir_src", 32'(PC_SOURCE), 32'd2);
    chk("brl_redir_flush", 32'(FLUSH_IF_DE), 32'd1);
    tick();
    nops(4);

    // interrupt entry on a full pipeline; INTR dropped after recognition
    exp_st = '{0, 1, 1, 1, 2, 0, 0, 0, 0};
    INTR = 1'b1; CSR_MIE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("int_state", 32'(STATE_DBG), 32'(exp_st[i]));
      chk("int_pulse", 32'(INT_TAKEN), 32'(i == 4));
      if (i == 4) chk("int_vec", 32'(PC_SOURCE), 32'd4);
      tick();
      INTR = 1'b0;
    end
    nops(4);

    // MEM_BUSY for 3 cycles inside DRAIN delays INT_TAKEN by 3
    exp_st = '{0, 1, 1, 1, 1, 1, 1, 2, 0};
    INTR = 1'b1;
    for (int i = 0; i < 9; i++) begin
      MEM_BUSY = (i >= 2 && i <= 4);
      cyc();
      chk("busy_state", 32'(STATE_DBG), 32'(exp_st[i]));
      chk("busy_pulse", 32'(INT_TAKEN), 32'(i == 7));
      if (i >= 2 && i <= 4)
        chk("busy_we", 32'({PC_WE, IF_DE_WE, DE_EX_WE, EX_MEM_WE, MEM_WB_WE}), 32'd0);
      tick();
      INTR = 1'b0;
    end
    MEM_BUSY = 1'b0;
    nops(4);

    // reset in the middle of a drain
    INTR = 1'b1;
    cyc(); tick();
    INTR = 1'b0;
    cyc(); chk("rd_in_drain", 32'(STATE_DBG), 32'd1); tick();
    RST = 1'b1; DEC_PC_SOURCE = 3'd3;
    cyc();
    chk("rd_async_state", 32'(STATE_DBG), 32'd0);
    chk("rd_async_bub", 32'(BUBBLE_DE_EX), 32'd0);
    chk("rd_async_src", 32'(PC_SOURCE), 32'd0);
    tick();
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rd_no_int", 32'(INT_TAKEN), 32'd0);
      chk("rd_run", 32'(STATE_DBG), 32'd0);
      tick();
    end
    DEC_PC_SOURCE = 3'd0;

    // lw x0 never creates a hazard
    DEC_IR = enc(OP_OP, 1, 0, 0, 0); EXE_IR = enc(OP_LD, 0, 1, 0, 2);
    cyc(); chk("x0_lu", 32'(PC_WE), 32'd1); tick();
    DEC_IR = enc(OP_BR, 0, 0, 0, 0); EXE_IR = enc(OP_IMM, 0, 0, 0, 0); MEM_IR = enc(OP_LD, 0, 1, 0, 2);
    cyc(); chk("x0_br", 32'(BUBBLE_DE_EX), 32'd0); tick();

    // SYSTEM writes rd only when func3 != 0
    DEC_IR = enc(OP_JALR, 0, 3, 0, 0); EXE_IR = enc(OP_SYS, 3, 0, 0, 1); MEM_IR = enc(OP_IMM, 0, 0, 0, 0);
    cyc(); chk("csr_dep", 32'(PC_WE), 32'd0); tick();
    EXE_IR = enc(OP_IMM, 0, 0, 0, 0);
    cyc(); tick();
    EXE_IR = enc(OP_SYS, 3, 0, 0, 0);
    cyc(); chk("sys_f3_0", 32'(PC_WE), 32'd1); tick();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      DEC_IR = rnd_ir(); EXE_IR = rnd_ir(); MEM_IR = rnd_ir();
      DEC_PC_SOURCE = 3'($urandom_range(0, 7));
      DEC_CLEAR = ($urandom_range(0, 3) == 0);
      MEM_BUSY  = ($urandom_range(0, 5) == 0);
      INTR      = ($urandom_range(0, 3) == 0);
      CSR_MIE   = ($urandom_range(0, 2) != 0);
      RST       = ($urandom_range(0, 99) == 0);
      cyc(); tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
